// File: rtl/load_store_unit_if.sv
// Request/response bundle between the control FSM (master) and the load/store unit (slave).
// Latency: none (wires only).
// Backpressure: req_ready gates acceptance; responses are never stalled.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word/double access to a 64-bit memory, RMW for sub-double stores.
// Latency: load 3 cycles, sub-double store 4, double store 2, misaligned (LSU_MISALIGN_CHECK_EN) 1.
// Backpressure: one access in flight, req_ready only in IDLE; resp_valid is a one-cycle pulse.
module load_store_unit (
  input  logic                    clk,
  input  logic                    rst_n,
  load_store_unit_if.slave        bus,
  output logic [63:0]             mem_addr,
  output logic                    mem_we,
  output logic [63:0]             mem_wdata,
  input  logic [63:0]             mem_rdata
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} state_t;

  state_t      state;
  logic [63:0] mdr;
  logic        write_q;
  logic [1:0]  size_q;
  logic        zext_q;
  logic [2:0]  off_q;
  logic [63:0] wdata_q;
  logic        load_done_q;

  logic [2:0]  req_off;
  logic        misaligned;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  // Replace only the addressed lanes of the old doubleword with the store data.
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wdata,
                                        input logic [1:0] size, input logic [2:0] off);
    logic [7:0]  lanes;
    logic [63:0] shifted;
    logic [63:0] result;
    lanes   = lane_mask(size, off);
    shifted = wdata << {off, 3'b000};
    for (int i = 0; i < 8; i++) begin
      result[8*i +: 8] = lanes[i] ? shifted[8*i +: 8] : old[8*i +: 8];
    end
    return result;
  endfunction

  // Shift the addressed lanes down to bit 0 and extend to 64 bits.
  function automatic logic [63:0] extract(input logic [63:0] dw, input logic [1:0] size,
                                          input logic zext, input logic [2:0] off);
    logic [63:0] shifted;
    logic [63:0] result;
    shifted = dw >> {off, 3'b000};
    case (size)
      2'd0:    result = zext ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1:    result = zext ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    result = zext ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: result = shifted;
    endcase
    return result;
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = |(bus.req_addr[2:0] & size_mask(bus.req_size));
`else
  // Without the check, stray low bits are dropped so the access is aligned down.
  assign misaligned = 1'b0;
  assign bus.resp_err = 1'b0;
`endif
  assign req_off = bus.req_addr[2:0] & ~size_mask(bus.req_size);

  // Load data is presented only during the RESP cycle of a completed load, zero otherwise.
  assign bus.resp_rdata = load_done_q ? extract(mdr, size_q, zext_q, off_q) : 64'b0;

  // Access sequencer: latches the request, drives memory and produces the response pulse.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      bus.resp_err   <= 1'b0;
`endif
      mem_addr       <= 64'b0;
      mem_we         <= 1'b0;
      mem_wdata      <= 64'b0;
      mdr            <= 64'b0;
      write_q        <= 1'b0;
      size_q         <= 2'd0;
      zext_q         <= 1'b0;
      off_q          <= 3'd0;
      wdata_q        <= 64'b0;
      load_done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write_q       <= bus.req_write;
            size_q        <= bus.req_size;
            zext_q        <= bus.req_unsigned;
            off_q         <= req_off;
            wdata_q       <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (misaligned) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
              bus.resp_err   <= 1'b1;
`endif
            end else begin
              mem_addr <= {bus.req_addr[63:3], 3'b000};
              if (bus.req_write && bus.req_size == 2'd3) begin
                state     <= WRITE;
                mem_we    <= 1'b1;
                mem_wdata <= bus.req_wdata;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          mdr <= mem_rdata;
          if (write_q) begin
            state     <= WRITE;
            mem_we    <= 1'b1;
            mem_wdata <= merge(mem_rdata, wdata_q, size_q, off_q);
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            load_done_q    <= 1'b1;
          end
        end
        WRITE: begin
          state          <= RESP;
          mem_we         <= 1'b0;
          bus.resp_valid <= 1'b1;
        end
        RESP: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
          load_done_q    <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
          bus.resp_err   <= 1'b0;
`endif
        end
        default: begin
          state          <= IDLE;
          mem_we         <= 1'b0;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
          load_done_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small synchronous-read memory model.
// Latency: each access is timed in cycles from its acceptance edge.
// Backpressure: one request at a time, issued only while the unit is idle.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  load_store_unit_if bus();

  load_store_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 8 doublewords, read data one cycle after the address.
  logic [63:0] mem [0:7];
  logic        pl_en;
  logic [2:0]  pl_idx;
  logic [63:0] pl_dat;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_dat;
    else if (mem_we) mem[mem_addr[5:3]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[5:3]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  int          r_lat;
  int          r_we_cnt;
  int          r_we_cyc;
  logic [63:0] r_rdata;
  logic        r_err;
  logic [63:0] r_wdata;
  logic [63:0] r_waddr;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [2:0] idx, input logic [63:0] dat);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_dat = dat;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [63:0] a, input logic [63:0] wd);
    @(negedge clk);
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
  endtask

  // Issue one access and watch cycles 1.. after acceptance until the response pulse.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [63:0] a, input logic [63:0] wd);
    r_lat = 0; r_we_cnt = 0; r_we_cyc = 0;
    r_rdata = '0; r_err = 1'b0; r_wdata = '0; r_waddr = '0;
    issue(w, sz, uns, a, wd);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_we) begin
        r_we_cnt++;
        r_we_cyc = c;
        r_wdata  = mem_wdata;
        r_waddr  = mem_addr;
      end
      if (bus.resp_valid) begin
        r_lat   = c;
        r_rdata = bus.resp_rdata;
        r_err   = bus.resp_err;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_req_ready"},  {63'b0, bus.req_ready},  64'd1);
    check_val({pfx, "_mem_we"},     {63'b0, mem_we},         64'd0);
    check_val({pfx, "_mem_addr"},   mem_addr,                64'd0);
    check_val({pfx, "_mem_wdata"},  mem_wdata,               64'd0);
    check_val({pfx, "_resp_valid"}, {63'b0, bus.resp_valid}, 64'd0);
    check_val({pfx, "_resp_rdata"}, bus.resp_rdata,          64'd0);
    check_val({pfx, "_resp_err"},   {63'b0, bus.resp_err},   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_in_reset;
    rst_n            = 1'b1;
    pl_en            = 1'b0;
    pl_idx           = 3'd0;
    pl_dat           = 64'd0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 64'd0;
    bus.req_wdata    = 64'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");

    // Loads from 0x10.
    preload(3'd2, 64'h1122334455667788);
    run_req(1'b0, 2'd0, 1'b0, 64'h17, 64'd0);
    check_val("lb_17_lat",   64'(r_lat),    64'd3);
    check_val("lb_17_data",  r_rdata,       64'h11);
    check_val("lb_17_we",    64'(r_we_cnt), 64'd0);
    run_req(1'b0, 2'd0, 1'b0, 64'h10, 64'd0);
    check_val("lb_10_sext",  r_rdata,       64'hFFFFFFFFFFFFFF88);
    run_req(1'b0, 2'd1, 1'b1, 64'h12, 64'd0);
    check_val("lhu_12",      r_rdata,       64'h5566);
    run_req(1'b0, 2'd2, 1'b0, 64'h14, 64'd0);
    check_val("lw_14",       r_rdata,       64'h11223344);
    run_req(1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
    check_val("ld_10",       r_rdata,       64'h1122334455667788);

    // Word sign/zero extension.
    preload(3'd2, 64'h0000000080000000);
    run_req(1'b0, 2'd2, 1'b0, 64'h10, 64'd0);
    check_val("lw_sext",     r_rdata,       64'hFFFFFFFF80000000);
    run_req(1'b0, 2'd2, 1'b1, 64'h10, 64'd0);
    check_val("lwu_zext",    r_rdata,       64'h0000000080000000);

    // Half store read-modify-write at 0x22.
    preload(3'd4, 64'hAAAAAAAAAAAAAAAA);
    run_req(1'b1, 2'd1, 1'b0, 64'h22, 64'h1234);
    check_val("sh_lat",      64'(r_lat),    64'd4);
    check_val("sh_we_cnt",   64'(r_we_cnt), 64'd1);
    check_val("sh_we_cyc",   64'(r_we_cyc), 64'd3);
    check_val("sh_wdata",    r_wdata,       64'hAAAAAAAA1234AAAA);
    check_val("sh_waddr",    r_waddr,       64'h20);
    check_val("sh_rdata",    r_rdata,       64'd0);

    // Byte store with junk in the upper store-data bits.
    run_req(1'b1, 2'd0, 1'b0, 64'h25, 64'hFFFFFFFFFFFFFF5A);
    check_val("sb_wdata",    r_wdata,       64'hAAAA5AAA1234AAAA);
    run_req(1'b0, 2'd3, 1'b0, 64'h20, 64'd0);
    check_val("ld_20_back",  r_rdata,       64'hAAAA5AAA1234AAAA);
    run_req(1'b0, 2'd0, 1'b1, 64'h25, 64'd0);
    check_val("lbu_25",      r_rdata,       64'h5A);

    // Double store skips the read.
    run_req(1'b1, 2'd3, 1'b0, 64'h08, 64'hDEADBEEFCAFEF00D);
    check_val("sd_lat",      64'(r_lat),    64'd2);
    check_val("sd_we_cyc",   64'(r_we_cyc), 64'd1);
    check_val("sd_we_cnt",   64'(r_we_cnt), 64'd1);
    check_val("sd_wdata",    r_wdata,       64'hDEADBEEFCAFEF00D);
    check_val("sd_waddr",    r_waddr,       64'h08);
    run_req(1'b0, 2'd3, 1'b0, 64'h08, 64'd0);
    check_val("ld_08_back",  r_rdata,       64'hDEADBEEFCAFEF00D);

    // Misaligned word load at 0x13 (mem[0x10] still 0x80000000).
    run_req(1'b0, 2'd2, 1'b0, 64'h13, 64'd0);
`ifdef LSU_MISALIGN_CHECK_EN
    check_val("mis_lat",     64'(r_lat),    64'd1);
    check_val("mis_err",     {63'b0, r_err}, 64'd1);
    check_val("mis_rdata",   r_rdata,       64'd0);
`else
    check_val("mis_lat",     64'(r_lat),    64'd3);
    check_val("mis_err",     {63'b0, r_err}, 64'd0);
    check_val("mis_rdata",   r_rdata,       64'hFFFFFFFF80000000);
`endif
    check_val("mis_we",      64'(r_we_cnt), 64'd0);

    // Reset during CAPTURE of a half store abandons the write.
    preload(3'd6, 64'h0123456789ABCDEF);
    issue(1'b1, 2'd1, 1'b0, 64'h30, 64'hBEEF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("midrst");
    we_in_reset = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_we) we_in_reset++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    if (mem_we) we_in_reset++;
    check_val("midrst_we",   64'(we_in_reset), 64'd0);
    run_req(1'b0, 2'd3, 1'b0, 64'h30, 64'd0);
    check_val("midrst_lat",  64'(r_lat),    64'd3);
    check_val("midrst_mem",  r_rdata,       64'h0123456789ABCDEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
